// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // First asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    pick_t      p;
    logic [1:0] k;
    p = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = ptr + 2'(i);
      if (!p.valid && req[k]) begin
        p.valid = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_func.sv
// Functional core: grant FSM, rotating priority pointer, tenure counter, OR4.
module gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_func
  import gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic            z,
  output logic [NREQ-1:0] gnt
);

  // Last counter value of a tenure; only meaningful when MAX_HOLD > 0.
  localparam int unsigned       LAST     = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAST);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       pri_q, pri_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  others;
  pick_t            pick_all, pick_oth;

  // State register: synchronous reset clears grant, priority and tenure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      pri_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant from idle, hold/saturate, preempt on tenure limit, hand off on release.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pri_d    = pri_q;
    cnt_d    = cnt_q;
    others   = req & ~(NREQ'(1) << owner_q);
    pick_all = rr_pick(req, pri_q);
    pick_oth = rr_pick(others, pri_q);
    case (state_q)
      IDLE: begin
        if (pick_all.valid) begin
          state_d = GRANT;
          owner_d = pick_all.idx;
          pri_d   = pick_all.idx + 2'd1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (req[owner_q]) begin
          if (MAX_HOLD == 0 || cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (pick_oth.valid) begin
            owner_d = pick_oth.idx;
            pri_d   = pick_oth.idx + 2'd1;
            cnt_d   = '0;
          end
        end else if (pick_oth.valid) begin
          // owner's bit is already low, so "others" equals the full request set here
          owner_d = pick_oth.idx;
          pri_d   = pick_oth.idx + 2'd1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: one-hot grant decoded from registered owner; Z is the raw OR4.
  always_comb begin
    gnt = '0;
    if (state_q == GRANT) gnt[owner_q] = 1'b1;
    z = |req;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv
// Cell wrapper: functional core plus timing arcs and checks.
module gf180mcu_fd_sc_mcu9t5v0__rrarb4_1
  import gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  output logic Z,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic G4,
  inout  wire  VDD,
  inout  wire  VSS
);

  logic [NREQ-1:0] gnt;
  logic            unused_pwr;

  // Supply pins carry no function.
  assign unused_pwr = VDD ^ VSS;

  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1_func #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_func (
    .clk (CLK),
    .rst (RST),
    .req ({A4, A3, A2, A1}),
    .z   (Z),
    .gnt (gnt)
  );

  assign {G4, G3, G2, G1} = gnt;

  specify
    (posedge CLK => G1) = (1.0, 1.0);
    (posedge CLK => G2) = (1.0, 1.0);
    (posedge CLK => G3) = (1.0, 1.0);
    (posedge CLK => G4) = (1.0, 1.0);
    (A1 => Z) = (1.0, 1.0);
    (A2 => Z) = (1.0, 1.0);
    (A3 => Z) = (1.0, 1.0);
    (A4 => Z) = (1.0, 1.0);
    $setuphold(posedge CLK, A1, 1.0, 1.0);
    $setuphold(posedge CLK, A2, 1.0, 1.0);
    $setuphold(posedge CLK, A3, 1.0, 1.0);
    $setuphold(posedge CLK, A4, 1.0, 1.0);
    $setuphold(posedge CLK, RST, 1.0, 1.0);
  endspecify

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv
// Bench for the round-robin arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=0)
// checked against a tenure-count reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1;

  logic       clk = 1'b0;
  logic       rst8, rst0;
  logic [3:0] a8, a0;
  logic [3:0] g8, g0;
  logic       z8, z0;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int checks = 0;
  int passes = 0;

  // Reference model state: owner (-1 = none), next priority start, cycles held so far.
  int m_own [2];
  int m_ptr [2];
  int m_held[2];
  int m_max [2] = '{8, 0};

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst8), .A1(a8[0]), .A2(a8[1]), .A3(a8[2]), .A4(a8[3]),
    .Z(z8), .G1(g8[0]), .G2(g8[1]), .G3(g8[2]), .G4(g8[3]), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .CLK(clk), .RST(rst0), .A1(a0[0]), .A2(a0[1]), .A3(a0[2]), .A4(a0[3]),
    .Z(z0), .G1(g0[0]), .G2(g0[1]), .G3(g0[2]), .G4(g0[3]), .VDD(vdd), .VSS(vss)
  );

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_g(input int d);
    if (m_own[d] < 0) return 4'b0000;
    return 4'(1) << m_own[d];
  endfunction

  task automatic model_step(input int d, input logic r_rst, input logic [3:0] r);
    int n;
    logic [3:0] oth;
    if (r_rst) begin
      m_own[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
    end else if (m_own[d] < 0 || !r[m_own[d]]) begin
      n = first_from(r, m_ptr[d]);
      if (n >= 0) begin
        m_own[d] = n; m_ptr[d] = (n + 1) % 4; m_held[d] = 1;
      end else begin
        m_own[d] = -1; m_held[d] = 0;
      end
    end else begin
      oth = r & ~(4'(1) << m_own[d]);
      if (m_max[d] != 0 && m_held[d] >= m_max[d] && oth != 4'b0000) begin
        n = first_from(oth, m_ptr[d]);
        m_own[d] = n; m_ptr[d] = (n + 1) % 4; m_held[d] = 1;
      end else begin
        m_held[d] = m_held[d] + 1;
      end
    end
  endtask

  // Advance one clock, update both models with the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    model_step(0, rst8, a8);
    model_step(1, rst0, a0);
    #1;
  endtask

  task automatic reset8();
    rst8 = 1'b1; a8 = 4'b0000;
    step();
    rst8 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; a8 = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (g8 !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", g8); else passes++;
      checks++;
      if (z8 !== 1'b1) $display("FAIL reset_z: got %b want 1", z8); else passes++;
    end
    rst8 = 1'b0;
    step();
    checks++;
    if (g8 !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", g8); else passes++;
  endtask

  task automatic test_rotation();
    logic [3:0] prev;
    int run;
    reset8();
    a8 = 4'b1111;
    prev = 4'b0000; run = 0;
    for (int i = 0; i < 41; i++) begin
      step();
      checks++;
      if (g8 !== exp_g(0)) $display("FAIL rotation[%0d]: got %b want %b", i, g8, exp_g(0)); else passes++;
      if (g8 == prev) run++;
      else begin
        if (prev != 4'b0000) begin
          checks++;
          if (run != 8) $display("FAIL rotation_tenure: got %0d cycles want 8", run); else passes++;
        end
        prev = g8; run = 1;
      end
    end
  endtask

  task automatic test_pulse();
    reset8();
    a8 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (g8 !== 4'b0100) $display("FAIL pulse_hold[%0d]: got %b want 0100", i, g8); else passes++;
    end
    a8 = 4'b0000;
    step();
    checks++;
    if (g8 !== 4'b0000) $display("FAIL pulse_drop: got %b want 0000", g8); else passes++;
    a8 = 4'b1001;
    step();
    checks++;
    if (g8 !== 4'b1000) $display("FAIL pulse_next_pri: got %b want 1000", g8); else passes++;
    checks++;
    if (g8 !== exp_g(0)) $display("FAIL pulse_model: got %b want %b", g8, exp_g(0)); else passes++;
  endtask

  task automatic test_saturate();
    reset8();
    a8 = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (g8 !== 4'b0010) $display("FAIL saturate[%0d]: got %b want 0010", i, g8); else passes++;
    end
    checks++;
    if (dut.u_func.cnt_q !== 4'd7) $display("FAIL saturate_cnt: got %0d want 7", dut.u_func.cnt_q); else passes++;
  endtask

  task automatic test_reset_mid();
    reset8();
    a8 = 4'b0001;
    step(); step();
    a8 = 4'b1001;
    step(); step();
    checks++;
    if (g8 !== 4'b0001) $display("FAIL midrst_owner: got %b want 0001", g8); else passes++;
    rst8 = 1'b1;
    step();
    checks++;
    if (g8 !== 4'b0000) $display("FAIL midrst_drop: got %b want 0000", g8); else passes++;
    rst8 = 1'b0;
    step();
    checks++;
    if (g8 !== 4'b0001) $display("FAIL midrst_regrant: got %b want 0001", g8); else passes++;
  endtask

  task automatic test_maxhold0();
    rst0 = 1'b1; a0 = 4'b0000;
    step();
    rst0 = 1'b0; a0 = 4'b0011;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (g0 !== 4'b0001) $display("FAIL mh0_hold[%0d]: got %b want 0001", i, g0); else passes++;
    end
    a0 = 4'b0010;
    step();
    checks++;
    if (g0 !== 4'b0010) $display("FAIL mh0_handoff: got %b want 0010", g0); else passes++;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        a8   = 4'($urandom_range(0, 15));
        a0   = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 12);
      end
      hold--;
      rst8 = ($urandom_range(0, 99) == 0);
      rst0 = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (z8 !== |a8) $display("FAIL rand_z8[%0d]: got %b want %b", i, z8, |a8); else passes++;
      step();
      checks++;
      if (g8 !== exp_g(0)) $display("FAIL rand_g8[%0d]: got %b want %b", i, g8, exp_g(0)); else passes++;
      checks++;
      if (g0 !== exp_g(1)) $display("FAIL rand_g0[%0d]: got %b want %b", i, g0, exp_g(1)); else passes++;
      checks++;
      if ($countones(g8) > 1 || $countones(g0) > 1)
        $display("FAIL rand_onehot[%0d]: got %b/%b want at most one hot", i, g8, g0);
      else passes++;
    end
    rst8 = 1'b0; rst0 = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
    end
    rst8 = 1'b1; rst0 = 1'b1; a8 = 4'b0000; a0 = 4'b0000;
    test_reset();
    test_rotation();
    test_pulse();
    test_saturate();
    test_reset_mid();
    test_maxhold0();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
